// File: rtl/mux_scan.sv
// Registered N-way channel mux with manual select handshake or timed auto-scan.
// Latency: one edge from cur_sel/in to out; sel_ready = ~mode, so manual offers stall while scanning.
module mux_scan #(
  parameter int SW    = 4,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(2**SW)*W-1:0]  in,
  input  logic                  mode,
  input  logic [SW-1:0]         sel_in,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  output logic [W-1:0]          out,
  output logic [SW-1:0]         out_sel,
  output logic                  out_valid,
  output logic                  scan_wrap
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t        state;
  logic [SW-1:0] cur_sel;
  logic [7:0]    cnt;
  logic [W-1:0]  chan;
  logic          accept;

  assign sel_ready = ~mode;
  assign accept    = sel_valid & sel_ready;
  assign chan      = in[cur_sel*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_sel   <= '0;
      cnt       <= '0;
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      // Output stage samples pre-edge selection; held at zero until a channel is chosen.
      out       <= (state != IDLE) ? chan : '0;
      out_sel   <= (state != IDLE) ? cur_sel : '0;
      out_valid <= (state != IDLE);
      scan_wrap <= 1'b0;

      case (state)
        IDLE: begin
          if (mode) begin
            state   <= SCAN;
            cur_sel <= '0;
            cnt     <= '0;
          end else if (accept) begin
            state   <= MANUAL;
            cur_sel <= sel_in;
          end
        end
        MANUAL: begin
          if (mode) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (accept) begin
            cur_sel <= sel_in;
          end
        end
        SCAN: begin
          if (!mode) begin
            // Leaving scan freezes the channel unless a select arrives in the same cycle.
            state <= MANUAL;
            cnt   <= '0;
            if (accept) cur_sel <= sel_in;
          end else if (cnt == DWELL_LAST) begin
            cnt     <= '0;
            cur_sel <= cur_sel + 1'b1;
            if (cur_sel == '1) scan_wrap <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
